spi_frame_decoder: RTL

//  Consumes 32-bit words + 1-cycle ready strobe from the SPI receive slave. Frames them into packets:

---
 rtl/spi_frame_decoder_pkg.sv | 33 +++
 rtl/spi_frame_decoder_buf.sv | 37 +++
 rtl/spi_frame_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_decoder_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder_pkg
// Shared definitions for the SPI frame decoder:
//   - state_e : HUNT / PAYLOAD / CHECK / DRAIN (2-bit encoding)
//   - err_e   : error codes reported on err_code
//   - DEFAULT_SYNC, DEFAULT_MAX_LEN, DEFAULT_TIMEOUT_CYC
//   - satInc16 : saturating 16-bit increment used by the drop counter
// -----------------------------------------------------------------------------
package spi_frame_decoder_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADLEN  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic [15:0] DEFAULT_SYNC        = 16'hA55A;
    localparam int          DEFAULT_MAX_LEN     = 16;
    localparam int          DEFAULT_TIMEOUT_CYC = 4096;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_frame_decoder_buf.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder_buf
// Payload buffer: DEPTH x 32 words, one synchronous write port and one
// combinational read port, so it maps onto distributed RAM.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module spi_frame_decoder_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // No reset on the storage: contents are only read back after being
    // written within the same packet.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_frame_decoder.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder
// Frames 32-bit words from the SPI receive slave into packets
// (header, LEN payload words, XOR checksum), buffers the payload and only
// releases it on a valid/ready stream once the checksum has matched.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   en                0 aborts any packet silently and holds HUNT
//   word_in/word_rdy  received word and its single-cycle strobe
//   out_data/chan/last/valid, out_ready   payload stream
//   pkt_ok / pkt_err  single-cycle result pulses
//   err_code          last error cause, held until the next pkt_err
//   drop_cnt          saturating count of discarded words
// -----------------------------------------------------------------------------
module spi_frame_decoder
    import spi_frame_decoder_pkg::*;
#(
    parameter logic [15:0] SYNC        = DEFAULT_SYNC,
    parameter int          MAX_LEN     = DEFAULT_MAX_LEN,
    parameter int          TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] word_in,
    input  logic        word_rdy,
    output logic [31:0] out_data,
    output logic [7:0]  out_chan,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic [15:0] drop_cnt
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e         state_q,    state_d;
    logic [7:0]     chan_q,     chan_d;
    logic [LW-1:0]  len_q,      len_d;
    logic [31:0]    csum_q,     csum_d;
    logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [TW-1:0]  tmo_q,      tmo_d;
    logic           pkt_ok_q,   pkt_ok_d;
    logic           pkt_err_q,  pkt_err_d;
    err_e           err_code_q, err_code_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;

    logic           buf_we;
    logic [31:0]    buf_rdata;
    logic           len_ok;
    logic           last_beat;
    logic           accept;

    spi_frame_decoder_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (word_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    assign len_ok    = (word_in[7:0] != 8'd0) && (int'(word_in[7:0]) <= MAX_LEN);
    assign last_beat = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));

    // The pkt_ok cycle is already in DRAIN but holds the stream back one
    // cycle so the first beat appears the cycle after the pulse.
    assign out_valid = en && (state_q == ST_DRAIN) && !pkt_ok_q;
    assign accept    = out_valid && out_ready;

    // Stream fields are forced to zero outside a beat so nothing undefined
    // from the unreset buffer ever reaches the pins.
    assign out_data  = out_valid ? buf_rdata : 32'd0;
    assign out_chan  = out_valid ? chan_q    : 8'd0;
    assign out_last  = out_valid && last_beat;

    assign pkt_ok    = pkt_ok_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign drop_cnt  = drop_cnt_q;

    // Next-state logic. A word strobe always takes priority over the
    // timeout, since it clears the counter in the same cycle.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tmo_d      = tmo_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        err_code_d = err_code_q;
        drop_cnt_d = drop_cnt_q;
        buf_we     = 1'b0;

        if (!en) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (word_rdy) begin
                        if (word_in[31:16] == SYNC) begin
                            if (len_ok) begin
                                chan_d   = word_in[15:8];
                                len_d    = word_in[LW-1:0];
                                csum_d   = word_in;
                                wr_ptr_d = '0;
                                tmo_d    = '0;
                                state_d  = ST_PAYLOAD;
                            end else begin
                                pkt_err_d  = 1'b1;
                                err_code_d = ERR_BADLEN;
                            end
                        end else begin
                            drop_cnt_d = satInc16(drop_cnt_q);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (word_rdy) begin
                        buf_we   = 1'b1;
                        csum_d   = csum_q ^ word_in;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        tmo_d    = '0;
                        if ({1'b0, wr_ptr_q} == (len_q - LW'(1))) begin
                            state_d = ST_CHECK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_HUNT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (word_rdy) begin
                        if (word_in == csum_q) begin
                            pkt_ok_d = 1'b1;
                            rd_ptr_d = '0;
                            state_d  = ST_DRAIN;
                        end else begin
                            pkt_err_d  = 1'b1;
                            err_code_d = ERR_CSUM;
                            state_d    = ST_HUNT;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_HUNT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (word_rdy) begin
                        drop_cnt_d = satInc16(drop_cnt_q);
                    end
                    if (accept) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        if (last_beat) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HUNT;
            chan_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tmo_q      <= tmo_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
